// File: rtl/exe_mem_stage_if.sv
// rtl/exe_mem_stage_if.sv - EX/MEM boundary bundle: execute-side input, memory-side output, redirect, debug
//
// Purpose: groups every non-clock/reset signal of exe_mem_stage so the stage and
// its neighbours share one declaration.
// Ports (signals):
//   execute side : in_valid, in_ready, alu_result, zero, rt_data, dest_reg,
//                  ctrl_in {mem_read, mem_write, reg_write, mem_to_reg},
//                  branch, branch_ne, branch_target, flush
//   memory side  : out_valid, out_ready, out_alu_result, out_rt_data,
//                  out_dest_reg, out_ctrl
//   redirect     : branch_taken, branch_pc
//   debug        : retired_count
// Modports: slave = the stage itself, master = its environment.

interface exe_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              zero;
  logic [DATA_W-1:0] rt_data;
  logic [REG_W-1:0]  dest_reg;
  logic [3:0]        ctrl_in;
  logic              branch;
  logic              branch_ne;
  logic [DATA_W-1:0] branch_target;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_rt_data;
  logic [REG_W-1:0]  out_dest_reg;
  logic [3:0]        out_ctrl;
  logic              branch_taken;
  logic [DATA_W-1:0] branch_pc;
  logic [CNT_W-1:0]  retired_count;

  modport slave (
    input  in_valid, alu_result, zero, rt_data, dest_reg, ctrl_in,
           branch, branch_ne, branch_target, flush, out_ready,
    output in_ready, out_valid, out_alu_result, out_rt_data, out_dest_reg,
           out_ctrl, branch_taken, branch_pc, retired_count
  );

  modport master (
    output in_valid, alu_result, zero, rt_data, dest_reg, ctrl_in,
           branch, branch_ne, branch_target, flush, out_ready,
    input  in_ready, out_valid, out_alu_result, out_rt_data, out_dest_reg,
           out_ctrl, branch_taken, branch_pc, retired_count
  );
endinterface

// File: rtl/exe_mem_stage.sv
// rtl/exe_mem_stage.sv - EX/MEM pipeline register with skid entry, branch redirect and retire counter
//
// Purpose: two-entry elastic buffer (main + skid) between execute and memory.
// Resolves beq/bne on accept and pulses a one-cycle redirect to fetch.
// Ports:
//   clk   - clock
//   rst_b - asynchronous active-low reset
//   bus   - exe_mem_stage_if.slave (handshakes, data, redirect, retired_count)

module exe_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  exe_mem_stage_if.slave   bus
);

  // main entry (visible at the outputs)
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_alu_q,   main_alu_d;
  logic [DATA_W-1:0] main_rt_q,    main_rt_d;
  logic [REG_W-1:0]  main_dest_q,  main_dest_d;
  logic [3:0]        main_ctrl_q,  main_ctrl_d;

  // skid entry (always younger than main)
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_alu_q,   skid_alu_d;
  logic [DATA_W-1:0] skid_rt_q,    skid_rt_d;
  logic [REG_W-1:0]  skid_dest_q,  skid_dest_d;
  logic [3:0]        skid_ctrl_q,  skid_ctrl_d;

  logic              taken_q,      taken_d;
  logic [DATA_W-1:0] branch_pc_q,  branch_pc_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;

  logic accept;
  logic handoff;

  // in_ready comes straight from a flop, so it is registered by construction
  assign bus.in_ready = !skid_valid_q;

  // flush blocks acceptance in the same cycle, which also suppresses any redirect
  assign accept  = bus.in_valid && !skid_valid_q && !bus.flush;
  assign handoff = main_valid_q && bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_alu_d   = main_alu_q;
    main_rt_d    = main_rt_q;
    main_dest_d  = main_dest_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_alu_d   = skid_alu_q;
    skid_rt_d    = skid_rt_q;
    skid_dest_d  = skid_dest_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (handoff || !main_valid_q) begin
      // main is free this cycle: refill from skid first to keep FIFO order
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_alu_d   = skid_alu_q;
        main_rt_d    = skid_rt_q;
        main_dest_d  = skid_dest_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_alu_d   = bus.alu_result;
        main_rt_d    = bus.rt_data;
        main_dest_d  = bus.dest_reg;
        main_ctrl_d  = bus.ctrl_in;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // main stalled: park the new entry in skid
      skid_valid_d = 1'b1;
      skid_alu_d   = bus.alu_result;
      skid_rt_d    = bus.rt_data;
      skid_dest_d  = bus.dest_reg;
      skid_ctrl_d  = bus.ctrl_in;
    end
  end

  always_comb begin
    // beq taken on zero=1, bne taken on zero=0
    taken_d     = accept && bus.branch && (bus.zero ^ bus.branch_ne);
    branch_pc_d = taken_d ? bus.branch_target : branch_pc_q;
    cnt_d       = handoff ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      main_valid_q <= 1'b0;
      main_alu_q   <= '0;
      main_rt_q    <= '0;
      main_dest_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_alu_q   <= '0;
      skid_rt_q    <= '0;
      skid_dest_q  <= '0;
      skid_ctrl_q  <= '0;
      taken_q      <= 1'b0;
      branch_pc_q  <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_alu_q   <= main_alu_d;
      main_rt_q    <= main_rt_d;
      main_dest_q  <= main_dest_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_alu_q   <= skid_alu_d;
      skid_rt_q    <= skid_rt_d;
      skid_dest_q  <= skid_dest_d;
      skid_ctrl_q  <= skid_ctrl_d;
      taken_q      <= taken_d;
      branch_pc_q  <= branch_pc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.out_valid      = main_valid_q;
  assign bus.out_alu_result = main_alu_q;
  assign bus.out_rt_data    = main_rt_q;
  assign bus.out_dest_reg   = main_dest_q;
  assign bus.out_ctrl       = main_ctrl_q;
  assign bus.branch_taken   = taken_q;
  assign bus.branch_pc      = branch_pc_q;
  assign bus.retired_count  = cnt_q;

endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
- Receiving end of the execute stage: captures the ALU result, zero flag, store data, destination register and MEM/WB control bits, and presents them to the memory stage.
- Elastic two-entry register (main + skid) with a valid/ready handshake on both sides, so a memory-stage stall never drops an execute result.
- Resolves beq/bne from the incoming zero flag and emits a one-cycle redirect to fetch.
- Keeps a retired-instruction counter for debug.

Parameters:
- DATA_W, 32, width of alu_result, rt_data, branch_target and their outputs.
- REG_W, 5, width of the destination register index.
- CNT_W, 32, width of retired_count.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept (registered).
- alu_result  in  DATA_W  ALU output.
- zero  in  1  ALU zero flag.
- rt_data  in  DATA_W  store data.
- dest_reg  in  REG_W  writeback register index.
- ctrl_in  in  4  {mem_read, mem_write, reg_write, mem_to_reg}.
- branch  in  1  instruction is a conditional branch.
- branch_ne  in  1  1 = bne, 0 = beq.
- branch_target  in  DATA_W  computed branch PC.
- flush  in  1  synchronous squash of all held entries.
- out_valid  out  1  main entry valid.
- out_ready  in  1  memory stage accepts.
- out_alu_result  out  DATA_W  held ALU result.
- out_rt_data  out  DATA_W  held store data.
- out_dest_reg  out  REG_W  held destination register.
- out_ctrl  out  4  held control bits, same order as ctrl_in.
- branch_taken  out  1  one-cycle redirect pulse.
- branch_pc  out  DATA_W  redirect target, valid while branch_taken is 1.
- retired_count  out  CNT_W  instructions handed to the memory stage.

Behaviour:
- Reset (rst_b low, asynchronous) forces:
  - main and skid valid to 0, so out_valid = 0.
  - in_ready = 1, branch_taken = 0, branch_pc = 0, retired_count = 0.
  - all out_* data/ctrl = 0.
  - Reset mid-operation discards held entries immediately, with no output pulse.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Hand-off when out_valid && out_ready.
  - Latency: 1 cycle from accept to out_valid when main is empty or handing off that cycle.
- in_ready is registered: in_ready = !skid_valid. A skid-full condition blocks input from the following cycle on.
- Per-cycle data movement (flush = 0):
  - Main empty or hand-off, skid empty: an accepted entry loads main.
  - Main full, no hand-off, accept: the entry loads skid, in_ready drops next cycle.
  - Hand-off with skid full: skid moves to main, skid empties. No accept is possible because in_ready = 0.
  - No hand-off: main holds all fields stable while out_valid = 1. The memory stage may sample at any cycle.
- Ordering is strictly FIFO: main always holds the older entry.
- Branch resolution:
  - On accept of an entry with branch = 1, taken = zero XOR branch_ne (beq taken on zero = 1, bne taken on zero = 0).
  - If taken: branch_taken = 1 for exactly the next cycle, with branch_pc = branch_target. Otherwise branch_taken stays 0.
  - branch_pc holds its last value when not taken.
  - The branch instruction still enters the buffer; its ctrl bits pass through unchanged.
  - The pulse is independent of out_ready, so a downstream stall does not delay the redirect.
- Flush:
  - Next cycle: main and skid invalid, in_ready = 1.
  - An input offered in the flush cycle is not accepted, and no branch_taken pulse results from it.
  - A branch_taken pulse already registered (accepted the previous cycle) still appears.
  - A hand-off coinciding with flush completes and is counted.
- retired_count:
  - Increments by 1 on each hand-off.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - Never decremented by flush.
- Data fields are unsigned bit copies: no arithmetic, sign extension or truncation.

Test Plan:
- Reset then single accept: alu_result=0x0000_0010, dest_reg=8, ctrl_in=4'b0010, out_ready=1 -> out_valid=1 the next cycle with identical fields; retired_count=1 one cycle after hand-off; in_ready stays 1.
- Back-pressure: out_ready=0, three back-to-back in_valid entries A, B, C -> A in main, B in skid, in_ready=0 after B, C held upstream; raise out_ready -> outputs A, B, C in order, each held stable while stalled.
- Branch: branch=1, branch_ne=0, zero=1, branch_target=0x0040_0020 -> branch_taken=1 for exactly one cycle with branch_pc=0x0040_0020. Repeat with branch_ne=1 -> no pulse. Both entries still reach the output.
- Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1; the offered entry is dropped; retired_count is unchanged unless a hand-off coincided.
- Async reset asserted mid-stall with skid full -> out_valid, branch_taken and retired_count go to 0 without waiting for a clock edge.
- Counter wrap: preload retired_count to 0xFFFF_FFFF via the bench, then one hand-off -> retired_count=0.
